// File: rtl/clb_pkg.sv
// rtl/clb_pkg.sv - shared LUT-RAM defaults and write-scheduler state encoding
package clb_pkg;

    localparam int LUT_ADDR_BITS = 4;

    typedef enum logic {
        LWS_IDLE  = 1'b0,
        LWS_WRITE = 1'b1
    } lws_state_t;

endpackage

// File: rtl/lutram_write_scheduler_rr_arbiter.sv
// rtl/lutram_write_scheduler_rr_arbiter.sv - combinational round-robin arbiter
module rr_arbiter
    import clb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int            idx;
    logic [IW-1:0] sel;

    // Scan upward from ptr with wrap; the first requester found wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            sel = IW'(idx);
            if (!any && req[sel]) begin
                any      = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/lutram_write_scheduler.sv
// rtl/lutram_write_scheduler.sv - serializes arbitrated word writes onto a single-bit LUT-RAM write port
module lutram_write_scheduler
    import clb_pkg::*;
#(
    parameter int ADDR_BITS = LUT_ADDR_BITS,
    parameter int NUM_REQ   = 2,
    parameter int WORD_BITS = 4,
    parameter int LEN_BITS  = $clog2(WORD_BITS + 1),
    parameter int GID_BITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cen,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_BITS-1:0]    req_len,
    input  logic [NUM_REQ*WORD_BITS-1:0]   req_data,
    output logic [ADDR_BITS-1:0]           waddr,
    output logic                           data_in,
    output logic                           write_en,
    output logic                           busy,
    output logic [GID_BITS-1:0]            grant_id,
    output logic                           done
);

    lws_state_t            state, state_next;
    logic [GID_BITS-1:0]   rr_ptr;
    logic [ADDR_BITS-1:0]  cur_addr;
    logic [LEN_BITS-1:0]   cnt;
    logic [WORD_BITS-1:0]  shreg;
    logic                  zero_done;

    logic [NUM_REQ-1:0]    gnt;
    logic [GID_BITS-1:0]   gnt_idx;
    logic                  any_req;
    logic                  accept;
    logic                  last_bit;
    logic [ADDR_BITS-1:0]  sel_addr;
    logic [LEN_BITS-1:0]   raw_len;
    logic [LEN_BITS-1:0]   sel_len;
    logic [WORD_BITS-1:0]  sel_data;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (GID_BITS)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    // Field mux for the winning requester; oversize lengths are clamped to a full word.
    always_comb begin
        sel_addr = req_addr[int'(gnt_idx)*ADDR_BITS +: ADDR_BITS];
        raw_len  = req_len[int'(gnt_idx)*LEN_BITS +: LEN_BITS];
        sel_data = req_data[int'(gnt_idx)*WORD_BITS +: WORD_BITS];
        sel_len  = (raw_len > LEN_BITS'(WORD_BITS)) ? LEN_BITS'(WORD_BITS) : raw_len;
    end

    always_comb begin
        accept     = (state == LWS_IDLE) && !cen && !rst && any_req;
        write_en   = (state == LWS_WRITE) && !cen;
        last_bit   = write_en && (cnt == LEN_BITS'(1));
        req_ready  = accept ? gnt : '0;
        waddr      = write_en ? cur_addr : '0;
        data_in    = write_en & shreg[0];
        busy       = (state == LWS_WRITE);
        done       = zero_done | last_bit;

        state_next = state;
        case (state)
            LWS_IDLE:  if (accept && (sel_len != '0)) state_next = LWS_WRITE;
            LWS_WRITE: if (last_bit) state_next = LWS_IDLE;
            default:   state_next = LWS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LWS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            cur_addr  <= '0;
            cnt       <= '0;
            shreg     <= '0;
            grant_id  <= '0;
            zero_done <= 1'b0;
        end else begin
            // A zero-length grant still owes its requester a done pulse one cycle later.
            zero_done <= accept && (sel_len == '0);
            if (accept) begin
                cur_addr <= sel_addr;
                cnt      <= sel_len;
                shreg    <= sel_data;
                grant_id <= gnt_idx;
                if (int'(gnt_idx) == NUM_REQ - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= gnt_idx + 1'b1;
                end
            end else if (write_en) begin
                cur_addr <= cur_addr + 1'b1;
                cnt      <= cnt - 1'b1;
                shreg    <= shreg >> 1;
            end
        end
    end

endmodule

// File: doc/lutram_write_scheduler.md
# lutram_write_scheduler

Shares the single-bit user write port of a SLICEM LUT-RAM latch block between several requesters. Each requester submits a multi-bit word write (base address, length, data); the block arbitrates round-robin, then serializes the accepted word one bit per cycle onto the latch block's `waddr`/`data_in`/`write_en` inputs. It sits between fabric-side write sources and the latch block. It stalls while block-style configuration (`cen`) is active.

## Interface
- `ADDR_BITS`, 4, LUT-RAM address width; `MEM_SIZE = 2**ADDR_BITS`.
- `NUM_REQ`, 2, number of requesters (2..4).
- `WORD_BITS`, 4, maximum bits per request (1..`MEM_SIZE`).
- `LEN_BITS`, `$clog2(WORD_BITS+1)`, width of the length field.

Ports:
- `clk` in 1: user-write clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `cen` in 1: configuration enable from the config chain; a high level stalls all writes.
- `req_valid` in `NUM_REQ`: request pending, one bit per requester.
- `req_ready` out `NUM_REQ`: one-hot acceptance pulse.
- `req_addr` in `NUM_REQ*ADDR_BITS`: base address; requester i uses slice i.
- `req_len` in `NUM_REQ*LEN_BITS`: number of bits to write, 0..`WORD_BITS`.
- `req_data` in `NUM_REQ*WORD_BITS`: write data, sent LSB first.
- `waddr` out `ADDR_BITS`: write address to the latch block.
- `data_in` out 1: write bit to the latch block.
- `write_en` out 1: write strobe to the latch block.
- `busy` out 1: high while in state WRITE.
- `grant_id` out `$clog2(NUM_REQ)`: requester currently being served.
- `done` out 1: one-cycle pulse when a request completes.

## Operation
- States:
  - IDLE: waits for a request to accept.
  - WRITE: serializes the captured word.
- IDLE behaviour:
  - When `cen` is 0 and any `req_valid` is high, grant the first valid requester at or after `rr_ptr`, scanning upward with wrap.
  - `req_ready[g]` is combinational and high in that cycle only.
  - At the clock edge, capture addr/len/data into `cur_addr`, `cnt = len`, `shreg = data`, `grant_id = g`. Set `rr_ptr = (g+1) mod NUM_REQ`.
  - If len > 0, go to WRITE. If len == 0, stay in IDLE and pulse `done` next cycle with no write.
- WRITE behaviour, per cycle while `cen` is 0:
  - Drive `write_en=1`, `waddr=cur_addr`, `data_in=shreg[0]`.
  - At the edge: `cur_addr += 1` (wraps mod `MEM_SIZE`), `shreg >>= 1`, `cnt -= 1`.
  - On the last bit (`cnt == 1`), `done=1` in the same cycle; then go to IDLE.
- While `cen` is 1, in any state:
  - `write_en=0` and `req_ready=0`.
  - Counters, shift register and state hold.
  - Writing resumes on the first cycle `cen` is 0.
- No acceptance happens in WRITE. Requesters hold `valid`/`addr`/`len`/`data` stable until they see `req_ready`.
- `req_len > WORD_BITS` is clamped to `WORD_BITS`.
- `waddr` and `data_in` are 0 whenever `write_en` is 0.

## Timing
- Reset values:
  - State IDLE; `rr_ptr=0`.
  - Outputs `write_en`, `waddr`, `data_in`, `busy`, `done`, `grant_id` and `req_ready` are all 0.
- Accept in cycle T. Bits are written in cycles T+1 .. T+len; `done` is high in cycle T+len. The next acceptance is possible at T+len+1. This assumes `cen` stays low; each `cen`-high cycle adds one cycle of delay.
- For len == 0: `done` pulses at T+1, with no `write_en`.
- `rst` mid-WRITE: the write is aborted, already-written bits stay in the RAM, and all outputs are 0 from the next cycle.
- Address wrap: base `MEM_SIZE-1`, len 2 writes addresses `MEM_SIZE-1`, then 0.

## Structure
- Shared package `clb_pkg`: `LUT_ADDR_BITS` default, and a state enum `lws_state_t {LWS_IDLE, LWS_WRITE}`.
- One sub-module, `rr_arbiter` (parameter `N`):
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `gnt[N]`, `gnt_idx`, `any`.
  - Purely combinational; the pointer register stays in the top module.

## Test plan
- Single request, reset, `cen=0`: req0 addr=3, len=4, data=4'b1011.
  - Required: cycles T+1..T+4 write (3,1), (4,1), (5,0), (6,1).
  - `done` at T+4, `busy` low at T+5.
- Round-robin, both requesters held valid continuously, each with len=1.
  - Required grant order: 0, 1, 0, 1.
  - Each `req_ready` is one cycle; acceptances are spaced 2 cycles apart.
- `cen` stall: assert `cen` for 3 cycles after the second bit of a len=4 write.
  - Required: `write_en` low for exactly those 3 cycles.
  - Bits 3 and 4 resume with the correct addresses; `done` is delayed by 3.
  - `cen` high in IDLE with valid: no `req_ready`.
- Wrap and zero length (`ADDR_BITS=4`):
  - addr=15, len=3 writes addresses 15, 0, 1.
  - len=0 gives `req_ready`, then `done` next cycle with no `write_en`.
- Reset mid-operation: assert `rst` after 2 of 4 bits.
  - Required: next cycle all outputs are 0 and the state is IDLE.
  - After reset, requester 0 has priority (`rr_ptr=0`).
- Clamp: len=7 with `WORD_BITS=4` writes exactly 4 bits.
